// File: rtl/pipe_skid_buffer_pkg.sv
// Shared definitions for the elastic pipeline register (skid buffer).
//   skid_state_t  : 2-bit state type; encoding equals the number of held entries
//   StEmpty/StOne/StFull : state constants
//   CountWidth    : width of the occupancy count output
package pipe_skid_buffer_pkg;

    localparam int unsigned CountWidth = 2;

    typedef logic [CountWidth-1:0] skid_state_t;

    // Encoding is chosen so that the state value is the occupancy count.
    localparam skid_state_t StEmpty = 2'd0;
    localparam skid_state_t StOne   = 2'd1;
    localparam skid_state_t StFull  = 2'd2;

endpackage

// File: rtl/pipe_skid_buffer_reg.sv
// Enabled pipeline register with asynchronous active-low reset to zero.
//   clk_i  : clock
//   rst_ni : asynchronous reset, active low
//   en_i   : load enable
//   d_i    : next value, captured when en_i is high
//   q_o    : registered value
module pipe_skid_buffer_reg #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready on both sides.
// o_ready and o_valid come straight from flops, so there is no combinational path
// from the consumer's i_ready back to the producer.
//   i_clk, i_reset   : clock, asynchronous active-high reset
//   i_flush          : synchronous squash of all held entries (and any same-cycle input)
//   i_valid, i_data  : producer side, o_ready back to producer
//   o_valid, o_data  : consumer side (main entry), i_ready from consumer
//   o_count          : number of held entries (0..2)
module pipe_skid_buffer
    import pipe_skid_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CountWidth-1:0] o_count
);

    skid_state_t           state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  main_en, skid_en, main_from_skid;
    logic                  in_xfer, out_xfer;
    logic                  rst_n;
    logic [DATA_WIDTH-1:0] main_d, main_q, skid_q;

    assign rst_n    = ~i_reset;
    assign in_xfer  = i_valid & ready_q;
    assign out_xfer = valid_q & i_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (i_flush) begin
            // Flush wins over any same-cycle input; data registers stay untouched.
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d = StOne;
                        main_en = 1'b1;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        state_d = StFull;
                        skid_en = 1'b1;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // o_ready is low here, so only the consumer can make progress.
                    if (out_xfer) begin
                        state_d        = StOne;
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
        valid_d = (state_d != StEmpty);
        ready_d = (state_d != StFull);
    end

    assign main_d = main_from_skid ? skid_q : i_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    pipe_skid_buffer_reg #(
        .Width (DATA_WIDTH)
    ) u_main_reg (
        .clk_i  (i_clk),
        .rst_ni (rst_n),
        .en_i   (main_en),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_skid_buffer_reg #(
        .Width (DATA_WIDTH)
    ) u_skid_reg (
        .clk_i  (i_clk),
        .rst_ni (rst_n),
        .en_i   (skid_en),
        .d_i    (i_data),
        .q_o    (skid_q)
    );

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_data  = main_q;
    assign o_count = state_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed vectors plus a random
// valid/ready run checked against a queue model.
module tb_pipe_skid_buffer;

    logic        i_clk;
    logic        i_reset;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [1:0]  o_count;

    int unsigned n_vec;
    int unsigned n_err;

    pipe_skid_buffer #(
        .DATA_WIDTH (32)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic v, input logic r,
                                input logic [1:0] cnt);
        check({tag, ".valid"}, 32'(o_valid), 32'(v));
        check({tag, ".ready"}, 32'(o_ready), 32'(r));
        check({tag, ".count"}, 32'(o_count), 32'(cnt));
    endtask

    // Random-run model state
    logic [31:0] model_q[$];
    logic        stall;
    logic [31:0] stall_data;
    logic [31:0] seq;
    logic        m_in, m_out;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        i_reset = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;

        // Reset state
        #2;
        expect_state("rst", 1'b0, 1'b1, 2'd0);
        check("rst.data", o_data, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Reset mid-stream, asynchronously between edges
        i_valid = 1'b1;
        i_data  = 32'hA5A5_A5A5;
        @(negedge i_clk);
        check("load.data", o_data, 32'hA5A5_A5A5);
        expect_state("load", 1'b1, 1'b1, 2'd1);
        i_valid = 1'b0;
        #2;
        i_reset = 1'b1;
        #1;
        expect_state("async_rst", 1'b0, 1'b1, 2'd0);
        check("async_rst.data", o_data, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Streaming with i_ready high: one payload per cycle, count stays 1
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'd1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge i_clk);
            check("stream.data", o_data, 32'(k));
            expect_state("stream", 1'b1, 1'b1, 2'd1);
            if (k == 4) i_valid = 1'b0;
            else i_data = 32'(k + 1);
        end
        @(negedge i_clk);
        expect_state("stream_end", 1'b0, 1'b1, 2'd0);

        // Backpressure: fill to two entries, hold off a third, then drain in order
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h11;
        @(negedge i_clk);
        expect_state("bp1", 1'b1, 1'b1, 2'd1);
        i_data = 32'h22;
        @(negedge i_clk);
        expect_state("bp2", 1'b1, 1'b0, 2'd2);
        check("bp2.data", o_data, 32'h11);
        i_data = 32'h33;
        @(negedge i_clk);
        expect_state("bp_hold", 1'b1, 1'b0, 2'd2);
        check("bp_hold.data", o_data, 32'h11);
        i_ready = 1'b1;
        @(negedge i_clk);
        check("bp_out2.data", o_data, 32'h22);
        expect_state("bp_out2", 1'b1, 1'b1, 2'd1);
        @(negedge i_clk);
        check("bp_out3.data", o_data, 32'h33);
        expect_state("bp_out3", 1'b1, 1'b1, 2'd1);
        i_valid = 1'b0;
        @(negedge i_clk);
        expect_state("bp_end", 1'b0, 1'b1, 2'd0);

        // Simultaneous input and output in ONE replaces main
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h5;
        @(negedge i_clk);
        check("simul1.data", o_data, 32'h5);
        i_data  = 32'h6;
        i_ready = 1'b1;
        @(negedge i_clk);
        check("simul2.data", o_data, 32'h6);
        expect_state("simul2", 1'b1, 1'b1, 2'd1);
        i_valid = 1'b0;
        @(negedge i_clk);
        expect_state("simul_end", 1'b0, 1'b1, 2'd0);

        // Flush in FULL with a pending input: everything is discarded
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h7;
        @(negedge i_clk);
        i_data = 32'h8;
        @(negedge i_clk);
        expect_state("fl_full", 1'b1, 1'b0, 2'd2);
        check("fl_full.data", o_data, 32'h7);
        i_data  = 32'h9;
        i_flush = 1'b1;
        @(negedge i_clk);
        expect_state("flush", 1'b0, 1'b1, 2'd0);
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        expect_state("flush_after", 1'b0, 1'b1, 2'd0);

        // Random valid/ready/flush against a queue model
        model_q.delete();
        stall = 1'b0;
        stall_data = '0;
        seq = 32'h1000;
        m_in = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            check("rnd.valid", 32'(o_valid), 32'(model_q.size() > 0));
            check("rnd.ready", 32'(o_ready), 32'(model_q.size() < 2));
            check("rnd.count", 32'(o_count), 32'(model_q.size()));
            check("rnd.ready_full", 32'(o_ready && (o_count == 2'd2)), 32'd0);
            if (model_q.size() > 0) check("rnd.data", o_data, model_q[0]);
            if (stall) check("rnd.stall", o_data, stall_data);

            // Producer holds its payload until it transfers (or is flushed)
            if (!i_valid || m_in || i_flush) begin
                i_valid = ($urandom_range(3) != 0);
                i_data  = seq;
                seq     = seq + 1;
            end
            i_ready = ($urandom_range(2) != 0);
            i_flush = ($urandom_range(63) == 0);

            m_in  = i_valid && (model_q.size() < 2);
            m_out = (model_q.size() > 0) && i_ready;
            stall = (model_q.size() > 0) && !i_ready && !i_flush;
            if (stall) stall_data = model_q[0];
            if (i_flush) begin
                model_q.delete();
            end else begin
                if (m_out) void'(model_q.pop_front());
                if (m_in) model_q.push_back(i_data);
            end
            @(negedge i_clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Elastic pipeline register for the pipelined core, with a valid/ready handshake on both sides.
- Sits between a producing stage (e.g. fetch) and a consuming stage (e.g. decode). It accepts writes from the producer and presents data to the consumer.
- Holds up to two entries, main plus skid, so that o_ready is a registered signal. This breaks the combinational ready path from consumer back to producer.
- Supports synchronous flush for branch/exception squash.

Parameters:
- DATA_WIDTH, 32, width of the payload carried per entry.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-high reset; clears all state immediately.
- i_flush  input  1  synchronous squash; discards all held entries.
- i_valid  input  1  producer has a payload on i_data.
- o_ready  output  1  buffer can accept a payload this cycle (registered).
- i_data  input  DATA_WIDTH  producer payload.
- o_valid  output  1  main entry holds a payload for the consumer.
- i_ready  input  1  consumer accepts the main entry this cycle.
- o_data  output  DATA_WIDTH  main entry payload.
- o_count  output  2  number of held entries (0..2), for debug and hazard logic.

Behaviour:
- Reset (asynchronous, active-high): state EMPTY; o_valid=0, o_ready=1, o_data=0, o_count=0, skid data=0. Takes effect mid-transfer with no completion of any pending handshake.
- Handshakes:
  - Input transfer: i_valid & o_ready at a rising edge.
  - Output transfer: o_valid & i_ready at a rising edge.
  - o_valid must not depend combinationally on i_ready.
  - o_ready is a flop output and must not depend combinationally on i_valid or i_ready.
- States:
  - EMPTY (count 0): o_valid=0, o_ready=1.
  - ONE (count 1): o_valid=1, o_ready=1.
  - FULL (count 2): o_valid=1, o_ready=0.
- Transitions, evaluated when not flushing:
  - EMPTY: input transfer -> ONE, i_data loaded into main. Otherwise stay.
  - ONE, input and output transfer together -> ONE, main replaced by i_data.
  - ONE, input only -> FULL, i_data loaded into skid.
  - ONE, output only -> EMPTY.
  - ONE, neither -> stay.
  - FULL, output transfer -> ONE, skid moves into main. Input is not possible because o_ready=0. Otherwise stay.
- Ordering: strict FIFO. Main is always older than skid, and no payload is duplicated or dropped.
- Latency:
  - From input transfer in EMPTY to o_valid: 1 cycle.
  - Steady-state throughput with i_ready held high: 1 payload per cycle.
- Flush:
  - i_flush=1 at an edge -> EMPTY next cycle (o_valid=0, o_ready=1, o_count=0).
  - An input transfer in the same cycle is also discarded, because flush has priority.
  - An output transfer in the same cycle still completes from the consumer's view. The consumer sampled valid data, and the data was valid before the edge.
- Data registers:
  - Load only on the transfers listed above.
  - o_data holds its value while stalled (o_valid=1, i_ready=0).
  - o_data is don't-care, but stable, when o_valid=0.
- Protocol assumption: the producer holds i_data and i_valid stable until transfer. The block does not check this.

Decomposition:
- Shared pipeline package: state enum (EMPTY, ONE, FULL) as a 2-bit typedef, plus the count width constant.
- The main and skid storage are each one instance of the team's enabled pipeline register.
  - Its reset is active-low, so drive it with the inverted i_reset.
  - Its load enable is computed by the control logic.
- The control FSM is coded inline. No other sub-module is needed.

Test Plan:
- Reset mid-stream: load 0xA5A5A5A5, then assert i_reset asynchronously between edges -> o_valid=0, o_ready=1 and o_count=0 immediately, without waiting for a clock edge.
- Streaming: i_ready=1, feed 1,2,3,4 back-to-back -> o_data 1,2,3,4 on consecutive cycles starting 1 cycle after the first input; o_count stays at 1.
- Backpressure: i_ready=0, send 0x11 then 0x22 -> o_count=2, o_ready=0, and 0x33 is held off. Release i_ready -> outputs 0x11, 0x22, 0x33 in order with no loss.
- Simultaneous input and output in ONE: main=0x5, i_valid=1 with data 0x6, i_ready=1 -> next o_data=0x6, o_count=1.
- Flush in FULL with i_valid=1: entries 0x7 and 0x8, input 0x9 -> next cycle o_valid=0 and o_count=0; 0x9 never appears.
- Random valid/ready (10k cycles) against a scoreboard queue -> exact ordering, o_ready never high when o_count=2, o_data stable whenever stalled.
